// File: rtl/ysyx_22050133_axi_sram_slave.sv
// ysyx_22050133_axi_sram_slave
// AXI-lite-style memory responder backed by a behavioural 64-bit word array.
// It is the slave end of the arbiter's master port. The read and write channels
// run independently and can be busy at the same time. Bursts are 1 beat (len=0)
// or 2 beats (len=1).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   axi_aw_*            write address  (ready out; valid, addr, len in)
//   axi_w_*             write data     (ready out; valid, data, strb in)
//   axi_b_*             write response (valid, resp out; ready in)
//   axi_ar_*            read address   (ready out; valid, addr, len in)
//   axi_r_*             read data      (valid, resp, data, last out; ready in)
//
// Optional build macro: AXI_SRAM_RAND_DELAY_EN. When it is defined, a 16-bit
// LFSR inserts 0..3 stall cycles before each ar_ready, aw_ready and w_ready
// assertion and before the first r_valid of a burst. This stresses the
// arbiter.
module ysyx_22050133_axi_sram_slave #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] MEM_BASE       = 32'h8000_0000,
  parameter int unsigned MEM_DEPTH      = 4096,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          axi_aw_ready_o,
  input  logic                          axi_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_i,
  input  logic                          axi_aw_len_i,
  output logic                          axi_w_ready_o,
  input  logic                          axi_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_i,
  input  logic                          axi_b_ready_i,
  output logic                          axi_b_valid_o,
  output logic [1:0]                    axi_b_resp_o,
  output logic                          axi_ar_ready_o,
  input  logic                          axi_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
  input  logic                          axi_ar_len_i,
  input  logic                          axi_r_ready_i,
  output logic                          axi_r_valid_o,
  output logic [1:0]                    axi_r_resp_o,
  output logic [AXI_DATA_WIDTH-1:0]     axi_r_data_o,
  output logic                          axi_r_last_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE_A = AXI_ADDR_WIDTH'(MEM_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP_A = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Byte address falls inside the memory window.
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_A;
    return (a >= BASE_A) && ((off >> OFF_W) < DEPTH_A);
  endfunction

  // Word index of a byte address; the low byte-offset bits are ignored.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_A;
    return IDX_W'(off >> OFF_W);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Read channel state
  logic [1:0]                r_state, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, r_addr_d;
  logic                      r_len, r_len_d;
  logic                      r_beat, r_beat_d;
  logic [CNT_W-1:0]          r_cnt, r_cnt_d;
  logic                      ar_ready_q, ar_ready_d;
  logic                      r_valid_q, r_valid_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                      r_last_q, r_last_d;

  // Write channel state
  logic [1:0]                w_state, w_state_d;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, w_addr_d;
  logic                      w_len, w_len_d;
  logic                      w_beat, w_beat_d;
  logic                      w_err, w_err_d;
  logic                      aw_ready_q, aw_ready_d;
  logic                      w_ready_q, w_ready_d;
  logic                      b_valid_q, b_valid_d;
  logic [1:0]                b_resp_q, b_resp_d;

  // Stall control: constant in the fixed-timing build
  logic [1:0]                rnd_c;
  logic                      ar_go_c, aw_go_c, w_go_c;

  // Read sample path: the address that the next registered data would come from
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_c;
  logic                      rd_ok_c;
  logic [IDX_W-1:0]          rd_idx_c;
  logic [AXI_DATA_WIDTH-1:0] rd_word_c;
  logic [CNT_W-1:0]          rd_first_wait_c;

  // Write path
  logic                      wr_hs_c;
  logic                      wr_ok_c;
  logic [IDX_W-1:0]          wr_idx_c;
  logic                      mem_we_c;

  always_comb begin
    rd_addr_c = r_addr;
    case (r_state)
      R_IDLE:  rd_addr_c = axi_ar_addr_i;
      R_DATA:  rd_addr_c = r_addr + STEP_A;
      default: rd_addr_c = r_addr;
    endcase
  end

  assign rd_ok_c         = addr_ok(rd_addr_c);
  assign rd_idx_c        = addr_idx(rd_addr_c);
  assign rd_word_c       = rd_ok_c ? mem[rd_idx_c] : '0;
  assign rd_first_wait_c = CNT_W'(RD_LATENCY) + CNT_W'(rnd_c);

  assign wr_hs_c  = (w_state == W_DATA) && axi_w_valid_i && w_ready_q;
  assign wr_ok_c  = addr_ok(w_addr);
  assign wr_idx_c = addr_idx(w_addr);
  assign mem_we_c = wr_hs_c && wr_ok_c;

  // Read FSM next-state and next-output
  always_comb begin
    r_state_d  = r_state;
    r_addr_d   = r_addr;
    r_len_d    = r_len;
    r_beat_d   = r_beat;
    r_cnt_d    = r_cnt;
    ar_ready_d = 1'b0;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    r_last_d   = r_last_q;
    case (r_state)
      R_IDLE: begin
        ar_ready_d = ar_go_c;
        if (axi_ar_valid_i && ar_ready_q) begin
          ar_ready_d = 1'b0;
          r_addr_d   = axi_ar_addr_i;
          r_len_d    = axi_ar_len_i;
          r_beat_d   = 1'b0;
          if (rd_first_wait_c == '0) begin
            r_state_d = R_DATA;
            r_valid_d = 1'b1;
            r_data_d  = rd_word_c;
            r_resp_d  = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_last_d  = ~axi_ar_len_i;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = rd_first_wait_c - CNT_W'(1);
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == '0) begin
          r_state_d = R_DATA;
          r_valid_d = 1'b1;
          r_data_d  = rd_word_c;
          r_resp_d  = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
          r_last_d  = ~r_len;
        end else begin
          r_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          if (r_len && !r_beat) begin
            // Second beat is sampled on the first beat's handshake edge
            r_beat_d = 1'b1;
            r_addr_d = r_addr + STEP_A;
            r_data_d = rd_word_c;
            r_resp_d = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_last_d = 1'b1;
          end else begin
            r_state_d  = R_IDLE;
            r_valid_d  = 1'b0;
            r_data_d   = '0;
            r_resp_d   = RESP_OKAY;
            r_last_d   = 1'b0;
            ar_ready_d = (rnd_c == 2'd0);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next-state and next-output
  always_comb begin
    w_state_d  = w_state;
    w_addr_d   = w_addr;
    w_len_d    = w_len;
    w_beat_d   = w_beat;
    w_err_d    = w_err;
    aw_ready_d = 1'b0;
    w_ready_d  = 1'b0;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    case (w_state)
      W_IDLE: begin
        aw_ready_d = aw_go_c;
        if (axi_aw_valid_i && aw_ready_q) begin
          aw_ready_d = 1'b0;
          w_addr_d   = axi_aw_addr_i;
          w_len_d    = axi_aw_len_i;
          w_beat_d   = 1'b0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
          w_ready_d  = (rnd_c == 2'd0);
        end
      end
      W_DATA: begin
        w_ready_d = w_go_c;
        if (wr_hs_c) begin
          w_err_d = w_err | ~wr_ok_c;
          if (w_beat == w_len) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = (w_err | ~wr_ok_c) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_beat_d  = 1'b1;
            w_addr_d  = w_addr + STEP_A;
            w_ready_d = (rnd_c == 2'd0);
          end
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) begin
          b_valid_d  = 1'b0;
          b_resp_d   = RESP_OKAY;
          w_state_d  = W_IDLE;
          aw_ready_d = (rnd_c == 2'd0);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      r_addr     <= '0;
      r_len      <= 1'b0;
      r_beat     <= 1'b0;
      r_cnt      <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
      w_state    <= W_IDLE;
      w_addr     <= '0;
      w_len      <= 1'b0;
      w_beat     <= 1'b0;
      w_err      <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      r_state    <= r_state_d;
      r_addr     <= r_addr_d;
      r_len      <= r_len_d;
      r_beat     <= r_beat_d;
      r_cnt      <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
      w_state    <= w_state_d;
      w_addr     <= w_addr_d;
      w_len      <= w_len_d;
      w_beat     <= w_beat_d;
      w_err      <= w_err_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Byte-strobed memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_w_strb_i[b]) mem[wr_idx_c][b*8 +: 8] <= axi_w_data_i[b*8 +: 8];
      end
    end
  end

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  logic [1:0]  ar_stall_q, ar_stall_d;
  logic [1:0]  aw_stall_q, aw_stall_d;
  logic [1:0]  w_stall_q, w_stall_d;

  assign rnd_c   = lfsr_q[1:0];
  assign ar_go_c = (ar_stall_q == 2'd0);
  assign aw_go_c = (aw_stall_q == 2'd0);
  assign w_go_c  = (w_stall_q == 2'd0);

  // Stall counters load on entry to a ready-asserting phase and count down in it
  always_comb begin
    ar_stall_d = ar_stall_q;
    aw_stall_d = aw_stall_q;
    w_stall_d  = w_stall_q;
    if (r_state == R_IDLE && ar_stall_q != 2'd0) ar_stall_d = ar_stall_q - 2'd1;
    if (r_state == R_DATA && r_state_d == R_IDLE) ar_stall_d = rnd_c;
    if (w_state == W_IDLE && aw_stall_q != 2'd0) aw_stall_d = aw_stall_q - 2'd1;
    if (w_state == W_RESP && w_state_d == W_IDLE) aw_stall_d = rnd_c;
    if (w_state == W_DATA && w_stall_q != 2'd0) w_stall_d = w_stall_q - 2'd1;
    if ((w_state == W_IDLE && w_state_d == W_DATA) || (wr_hs_c && (w_beat != w_len)))
      w_stall_d = rnd_c;
  end

  // Fibonacci LFSR, taps 16/14/13/11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= 16'hACE1;
      ar_stall_q <= 2'd0;
      aw_stall_q <= 2'd0;
      w_stall_q  <= 2'd0;
    end else begin
      lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      ar_stall_q <= ar_stall_d;
      aw_stall_q <= aw_stall_d;
      w_stall_q  <= w_stall_d;
    end
  end
`else
  assign rnd_c   = 2'd0;
  assign ar_go_c = 1'b1;
  assign aw_go_c = 1'b1;
  assign w_go_c  = 1'b1;
`endif

  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_data_o   = r_data_q;
  assign axi_r_last_o   = r_last_q;
  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;

endmodule

// File: doc/ysyx_22050133_axi_sram_slave.md
Name: ysyx_22050133_axi_sram_slave

Overview:
- AXI-lite-style memory responder: the slave end of the arbiter's master port.
- Accepts AR/AW/W requests and returns R/B responses from an internal 64-bit-wide behavioural memory array.
- Read and write channels run independently and concurrently.
- Bursts are limited to 1 beat (len=0) or 2 beats (len=1), matching the single-bit len carried by the arbiter.

Parameters:
- AXI_DATA_WIDTH, 64, data bus width; memory word width.
- AXI_ADDR_WIDTH, 32, address width.
- MEM_BASE, 32'h8000_0000, byte address of word 0.
- MEM_DEPTH, 4096, number of 64-bit words.
- RD_LATENCY, 1, extra cycles between AR handshake and first R valid (0..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- axi_aw_ready_o  out  1  write-address ready
- axi_aw_valid_i  in  1  write-address valid
- axi_aw_addr_i  in  AXI_ADDR_WIDTH  write byte address
- axi_aw_len_i  in  1  0 = 1 beat, 1 = 2 beats
- axi_w_ready_o  out  1  write-data ready
- axi_w_valid_i  in  1  write-data valid
- axi_w_data_i  in  AXI_DATA_WIDTH  write data
- axi_w_strb_i  in  AXI_DATA_WIDTH/8  byte enables
- axi_b_ready_i  in  1  response ready
- axi_b_valid_o  out  1  response valid
- axi_b_resp_o  out  2  00 OKAY, 10 SLVERR
- axi_ar_ready_o  out  1  read-address ready
- axi_ar_valid_i  in  1  read-address valid
- axi_ar_addr_i  in  AXI_ADDR_WIDTH  read byte address
- axi_ar_len_i  in  1  0 = 1 beat, 1 = 2 beats
- axi_r_ready_i  in  1  read-data ready
- axi_r_valid_o  out  1  read-data valid
- axi_r_resp_o  out  2  00 OKAY, 10 SLVERR
- axi_r_data_o  out  AXI_DATA_WIDTH  read data
- axi_r_last_o  out  1  high on final beat

Behaviour:
- Reset:
  - Asynchronous, rst_n low: all outputs 0, both FSMs to IDLE, counters 0.
  - Memory contents are not cleared.
  - Ready outputs rise on the first clk edge after rst_n deasserts.
  - Reset mid-transaction abandons it; no R/B is issued for it.
- Addressing:
  - Word index = (addr - MEM_BASE) >> 3; addr[2:0] ignored.
  - Out of range (addr < MEM_BASE or index >= MEM_DEPTH): read data 0, resp SLVERR, writes dropped, resp SLVERR.
  - Beat 2 address = beat 1 address + 8, range-checked per beat.
  - Burst resp is SLVERR if any beat errs.
- Read FSM (R_IDLE, R_WAIT, R_DATA):
  - R_IDLE: ar_ready=1. On ar_valid&ar_ready, latch addr/len, load counter = RD_LATENCY; go to R_WAIT, or to R_DATA if RD_LATENCY=0. ar_ready drops the next cycle.
  - R_WAIT: decrement counter; at 0, register memory word into r_data and go to R_DATA. First r_valid occurs RD_LATENCY+1 cycles after the AR edge.
  - R_DATA: r_valid=1; data/resp/last held stable until r_ready.
    - On handshake with beats remaining: next beat data registered and presented the very next cycle.
    - On the final beat: go to R_IDLE with ar_ready=1 the next cycle.
  - r_last=1 on beat 1 when len=0, on beat 2 when len=1.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: aw_ready=1, w_ready=0. W presented before AW waits. On AW handshake, latch addr/len and go to W_DATA.
  - W_DATA: w_ready=1. Each W handshake writes the bytes whose strb bit is set, at that clk edge. After len+1 beats go to W_RESP.
  - W_RESP: b_valid=1 with resp, held until b_ready; then W_IDLE.
- Simultaneous events:
  - Read sample and write of the same word on the same edge: read returns old data.
  - AR and AW accepted in the same cycle: both proceed independently.
  - Valid/data from the master may change only after a handshake; the slave does not check this.

Optional Feature:
- AXI_SRAM_RAND_DELAY_EN defined:
  - 16-bit LFSR (seed 16'hACE1 at reset) adds 0..3 extra stall cycles (LFSR[1:0]) before each ar_ready, aw_ready, w_ready and first r_valid assertion.
  - Used to stress the arbiter.
- Undefined: fixed timing exactly as above; no LFSR logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-burst -> all valid/ready 0 during reset; ar_ready=aw_ready=1 one cycle after release; no stale R/B.
- Single write then read:
  - AW 0x8000_0010 len0, W data 64'h1122334455667788 strb 8'hFF -> b_valid resp 00.
  - Then AR same addr -> r_valid at AR+2 cycles (RD_LATENCY=1), data 64'h1122334455667788, last=1.
- Strobed write: W strb 8'h0F data 64'hFFFFFFFF_AAAAAAAA over prior word -> readback 64'h11223344_AAAAAAAA.
- Two-beat read at 0x8000_0010 len1 with r_ready low 2 cycles on beat 1:
  - Beat 1 data held stable; last=0.
  - Beat 2 = word at 0x8000_0018, last=1.
  - ar_ready returns the next cycle.
- Out of range: AR 0x7FFF_FFF8 -> r_resp 10, data 0. AW 0x8000_8000 (MEM_DEPTH 4096) -> b_resp 10, memory unchanged.
- Concurrency: AR and AW issued same cycle to the same word; W edge coincides with read sample -> R returns old data, B OKAY, and a subsequent read returns new data.
